cpu_muldiv_unit: RTL and testbench

- Iterative multiply/divide execution unit sitting directly downstream of the CPU register file.
- Consumes the two register read ports (REG_1_OUT, REG_2_OUT) as operands.
- Produces a write-back value plus a 4-bit destination select that drive the register file's REG_BUS and REG_SEL.
- Fixed-latency, one-operation-at-a-time block with a start/busy/done handshake to the control sequencer.

---
 rtl/cpu_muldiv_unit_if.sv | 14 +
 rtl/cpu_muldiv_unit.sv | 74 +++++++
 tb/tb_cpu_muldiv_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_muldiv_unit_if.sv
// cpu_muldiv_unit_if: start/busy/done handshake and write-back bus of the multiply/divide unit
interface cpu_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] OP_A;
  logic [WIDTH-1:0] OP_B;
  logic [3:0]       DEST;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic [3:0]       WB_SEL;
  modport master (output START, OP, OP_A, OP_B, DEST, input BUSY, DONE, RESULT, WB_SEL);
  modport slave  (input START, OP, OP_A, OP_B, DEST, output BUSY, DONE, RESULT, WB_SEL);
endinterface

// File: rtl/cpu_muldiv_unit.sv
// cpu_muldiv_unit: iterative unsigned multiply/divide, one bit per cycle, fixed WIDTH-cycle latency
module cpu_muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input logic CLK,
  input logic CLR_N,
  cpu_muldiv_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [3:0]         dest_q, dest_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  // acc holds {high, low}: product bits for MUL, {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = acc_q[0] ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q} : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    // a zero divisor never borrows, giving all-ones quotient and remainder = dividend
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dest_d  = dest_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (state_q == IDLE && bus.START) begin
      state_d = CALC;
      cnt_d   = '0;
      op_d    = bus.OP;
      dest_d  = bus.DEST;
      b_d     = bus.OP_B;
      acc_d   = {{WIDTH{1'b0}}, bus.OP_A};
    end else if (state_q == CALC) begin
      acc_d   = op_q[1] ? div_next : mul_next;
      cnt_d   = cnt_q + CNT_BITS'(1);
      state_d = (cnt_q == CNT_BITS'(WIDTH - 1)) ? WB : CALC;
    end else if (state_q == WB) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end
  assign bus.BUSY   = state_q != IDLE;
  assign bus.DONE   = state_q == WB;
  assign bus.WB_SEL = bus.DONE ? dest_q : 4'hF;
  assign bus.RESULT = !bus.DONE ? '0 : op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// tb_cpu_muldiv_unit: random and directed operations checked against an arithmetic reference model
module tb_cpu_muldiv_unit;
  logic CLK = 1'b0;
  logic CLR_N = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 CLK = ~CLK;
  cpu_muldiv_unit_if #(.WIDTH(32)) bus ();
  cpu_muldiv_unit #(.WIDTH(32), .CNT_BITS(6)) dut (.CLK(CLK), .CLR_N(CLR_N), .bus(bus));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check(tag, {bus.BUSY, bus.DONE, bus.WB_SEL, bus.RESULT}, {1'b0, 1'b0, 4'hF, 32'h0});
  endtask
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] d);
    bus.START = 1'b1; bus.OP = op; bus.OP_A = a; bus.OP_B = b; bus.DEST = d;
    tick();
    bus.START = 1'b0; bus.OP = 2'($urandom); bus.OP_A = $urandom; bus.OP_B = $urandom; bus.DEST = 4'($urandom);
  endtask
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.DONE && n < 60) begin
      check("calc", {bus.BUSY, bus.WB_SEL, bus.RESULT}, {1'b1, 4'hF, 32'h0});
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd33);
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] d);
    int n;
    start_op(op, a, b, d);
    wait_done(n);
    check("wb", {bus.BUSY, bus.DONE, bus.WB_SEL, bus.RESULT}, {1'b1, 1'b1, d, model(op, a, b)});
    tick();
    check_idle("after_wb");
  endtask
  initial begin
    int n, dones;
    logic [31:0] a, b;
    bus.START = 1'b0; bus.OP = 2'd0; bus.OP_A = '0; bus.OP_B = '0; bus.DEST = 4'd0;
    tick(); tick();
    CLR_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_idle("reset_idle");
      tick();
    end
    run_op(2'd0, 32'd7, 32'd6, 4'd3);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
    run_op(2'd2, 32'd100, 32'd7, 4'd4);
    run_op(2'd3, 32'd100, 32'd7, 4'd5);
    run_op(2'd2, 32'd5, 32'd0, 4'd6);
    run_op(2'd3, 32'd5, 32'd0, 4'd7);
    run_op(2'd2, 32'd3, 32'd9, 4'hF);
    // START during CALC and in the WB cycle must be dropped, not queued
    start_op(2'd2, 32'd100, 32'd7, 4'd5);
    repeat (4) tick();
    bus.START = 1'b1; bus.OP = 2'd0; bus.DEST = 4'd9;
    tick();
    bus.START = 1'b0;
    n = 6;
    while (!bus.DONE && n < 60) begin
      tick();
      n++;
    end
    check("ign_latency", 64'(n), 64'd33);
    check("ign_wb", {bus.WB_SEL, bus.RESULT}, {4'd5, 32'd14});
    bus.START = 1'b1; bus.OP = 2'd0; bus.OP_A = 32'd3; bus.OP_B = 32'd3; bus.DEST = 4'd10;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_idle("ign_not_queued");
      tick();
    end
    run_op(2'd0, 32'd3, 32'd3, 4'd10);
    // reset mid-operation aborts without write-back
    start_op(2'd0, 32'd7, 32'd6, 4'd3);
    repeat (9) tick();
    CLR_N = 1'b0;
    tick();
    CLR_N = 1'b1;
    check_idle("abort");
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.DONE || bus.WB_SEL != 4'hF) dones++;
      tick();
    end
    check("abort_no_done", 64'(dones), 64'd0);
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(2'($urandom), a, b, 4'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
